// File: rtl/vga_pixel_fetch_pkg.sv
// Shared constants and types for the camera-to-VGA path (capture, timing, fetch).
package vga_pixel_fetch_pkg;

    localparam int RGB_W      = 12;   // RGB444
    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;
    localparam int ADDR_W_DEF = 17;
    localparam int CNT_W      = 10;   // x/y counter width from the timing generator

    // VGA syncs are active-low; the idle level is what the delay taps reset to.
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = ~SYNC_ACTIVE;

    typedef logic [RGB_W-1:0] rgb_t;

    // Control bits that travel alongside the BRAM read so they line up with rd_data.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic in_fb;
    } align_t;

    localparam align_t ALIGN_RST = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, de: 1'b0, in_fb: 1'b0};

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port: the fetch block is the master, the BRAM the slave.
// Read semantics: no handshake -- when rd_en is high the BRAM returns the word at
// rd_addr on rd_data a fixed RD_LAT cycles later; there is no backpressure.
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 17
) ();
    logic              rd_en;
    logic [ADDR_W:0]   rd_addr;   // {buffer half, pixel index}
    logic [11:0]       rd_data;   // RGB444

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_pixel_fetch_sync_delay_line.sv
// Fixed-depth shift register with a per-bit reset value, used to align syncs and
// qualifiers with the BRAM read latency.
module sync_delay_line #(
    parameter int           W       = 4,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] taps [DEPTH];

    // Shift one tap per clock; reset loads every tap with the idle pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= RST_VAL;
            end
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch: maps VGA x/y onto the (upscaled) camera framebuffer, issues BRAM reads
// and re-aligns syncs/data-enable with the returned colour. Total latency RD_LAT+2.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int   FB_W     = FB_W_DEF,
    parameter int   FB_H     = FB_H_DEF,
    parameter int   SCALE_SH = 1,
    parameter int   ADDR_W   = ADDR_W_DEF,
    parameter int   RD_LAT   = 1,
    parameter rgb_t BORDER   = 12'h000
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    input  logic             video_on,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             buf_sel,
    vga_pixel_fetch_if.master fb,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o
);

    // Stage 0 register plus the delay line make up the full RD_LAT+2 latency.
    localparam int DLY_DEPTH = RD_LAT + 1;

    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
    localparam logic [CNT_W:0]    FB_W_C = (CNT_W + 1)'(FB_W);
    localparam logic [CNT_W:0]    FB_H_C = (CNT_W + 1)'(FB_H);
    localparam logic [CNT_W-1:0]  Y_MASK = CNT_W'((1 << SCALE_SH) - 1);

    logic [CNT_W-1:0]  x_q, y_q;
    logic              video_on_q, hsync_q, vsync_q;
    logic              buf_q;
    logic [ADDR_W-1:0] row_base;
    logic [CNT_W-1:0]  col, row;
    logic              in_fb;
    logic [ADDR_W-1:0] pix_idx;
    align_t            align_in, align_out;
    rgb_t              rgb;

    // Stage 0: register timing inputs; the displayed buffer half only switches at frame start.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            video_on_q <= 1'b0;
            hsync_q    <= SYNC_IDLE;
            vsync_q    <= SYNC_IDLE;
            buf_q      <= 1'b0;
        end else begin
            x_q        <= x;
            y_q        <= y;
            video_on_q <= video_on;
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            if (x == '0 && y == '0) begin
                buf_q <= buf_sel;
            end
        end
    end

    // Row start index, stepped by one framebuffer line every 2^SCALE_SH display lines.
    // Updated from the raw counters so it is ready when the same x==0 reaches stage 1.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            row_base <= '0;
        end else if (x == '0) begin
            if (y == '0) begin
                row_base <= '0;
            end else if ((y & Y_MASK) == '0) begin
                row_base <= row_base + FB_W_A;
            end
        end
    end

    assign col     = x_q >> SCALE_SH;
    assign row     = y_q >> SCALE_SH;
    assign in_fb   = video_on_q && ({1'b0, col} < FB_W_C) && ({1'b0, row} < FB_H_C);
    assign pix_idx = row_base + ADDR_W'(col);

    // Stage 1: issue the BRAM read; the address holds while no read is requested.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            fb.rd_en   <= 1'b0;
            fb.rd_addr <= '0;
        end else begin
            fb.rd_en <= in_fb;
            if (in_fb) begin
                fb.rd_addr <= {buf_q, pix_idx};
            end
        end
    end

    assign align_in = '{hsync: hsync_q, vsync: vsync_q, de: video_on_q, in_fb: in_fb};

    sync_delay_line #(
        .W       ($bits(align_t)),
        .DEPTH   (DLY_DEPTH),
        .RST_VAL (ALIGN_RST)
    ) u_align (
        .clk (pclk),
        .rst (rst),
        .d   (align_in),
        .q   (align_out)
    );

    // Colour select: BRAM data inside the picture, border outside it, black in blanking.
    always_comb begin
        rgb = '0;
        if (align_out.de) begin
            rgb = align_out.in_fb ? fb.rd_data : BORDER;
        end
    end

    assign vga_r   = rgb[11:8];
    assign vga_g   = rgb[7:4];
    assign vga_b   = rgb[3:0];
    assign hsync_o = align_out.hsync;
    assign vsync_o = align_out.vsync;
    assign de_o    = align_out.de;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a 320-wide instance (1:1 fill of 640x480)
// and a 256-wide instance with a visible border colour, driven by the same counters.
module tb_vga_pixel_fetch;
  import vga_pixel_fetch_pkg::*;

  localparam int          AW       = 17;
  localparam logic [11:0] BORDER_B = 12'h5A5;

  typedef struct {
    bit v;
    int x;
    int y;
    bit von;
    bit hs;
    bit vs;
    bit bsel;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       video_on = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       buf_sel = 1'b0;

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t h0, h1, h2;
  bit   exp_buf = 1'b0;

  always #5 pclk = ~pclk;

  vga_pixel_fetch_if #(.ADDR_W(AW)) bus_a ();
  vga_pixel_fetch_if #(.ADDR_W(AW)) bus_b ();

  vga_pixel_fetch #(.ADDR_W(AW)) dut_a (
    .pclk (pclk), .rst (rst), .x (x), .y (y), .video_on (video_on),
    .hsync (hsync), .vsync (vsync), .buf_sel (buf_sel), .fb (bus_a.master),
    .vga_r (r_a), .vga_g (g_a), .vga_b (b_a),
    .hsync_o (hs_a), .vsync_o (vs_a), .de_o (de_a)
  );

  vga_pixel_fetch #(.FB_W(256), .ADDR_W(AW), .BORDER(BORDER_B)) dut_b (
    .pclk (pclk), .rst (rst), .x (x), .y (y), .video_on (video_on),
    .hsync (hsync), .vsync (vsync), .buf_sel (buf_sel), .fb (bus_b.master),
    .vga_r (r_b), .vga_g (g_b), .vga_b (b_b),
    .hsync_o (hs_b), .vsync_o (vs_b), .de_o (de_b)
  );

  // ---------------- BRAM models (RD_LAT = 1) ----------------
  function automatic logic [11:0] bram_word(input logic [AW:0] a);
    return a[11:0] ^ 12'hABC;
  endfunction

  always @(posedge pclk) if (bus_a.rd_en) bus_a.rd_data <= bram_word(bus_a.rd_addr);
  always @(posedge pclk) if (bus_b.rd_en) bus_b.rd_data <= bram_word(bus_b.rd_addr);

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit exp_in_fb(input vec_t v, input int fbw);
    return v.v && v.von && ((v.x >> 1) < fbw) && ((v.y >> 1) < 240);
  endfunction

  function automatic logic [AW:0] exp_addr(input vec_t v, input int fbw);
    int idx;
    idx = (v.y >> 1) * fbw + (v.x >> 1);
    return {v.bsel, AW'(idx)};
  endfunction

  task automatic clear_hist();
    h0 = '{v: 1'b0, x: 0, y: 0, von: 1'b0, hs: 1'b1, vs: 1'b1, bsel: 1'b0};
    h1 = h0;
    h2 = h0;
  endtask

  // h1 is the vector now at the read port, h2 the one now at the colour outputs.
  task automatic check_pipe(input string dn, input int fbw, input logic [11:0] border,
                            input logic en, input logic [AW:0] addr, input logic [11:0] rgb,
                            input logic hs, input logic vs, input logic de);
    logic        e_en;
    logic [11:0] e_rgb;
    string       t1, t2;
    e_en = exp_in_fb(h1, fbw);
    t1 = $sformatf("%s x=%0d y=%0d", dn, h1.x, h1.y);
    t2 = $sformatf("%s x=%0d y=%0d", dn, h2.x, h2.y);
    check({t1, " rd_en"}, 32'(en), 32'(e_en));
    if (e_en) check({t1, " rd_addr"}, 32'(addr), 32'(exp_addr(h1, fbw)));
    if (!h2.v || !h2.von) e_rgb = 12'h000;
    else if (exp_in_fb(h2, fbw)) e_rgb = bram_word(exp_addr(h2, fbw));
    else e_rgb = border;
    check({t2, " rgb"}, 32'(rgb), 32'(e_rgb));
    check({t2, " hsync_o"}, 32'(hs), 32'(h2.v ? h2.hs : 1'b1));
    check({t2, " vsync_o"}, 32'(vs), 32'(h2.v ? h2.vs : 1'b1));
    check({t2, " de_o"}, 32'(de), 32'(h2.v && h2.von));
  endtask

  task automatic check_reset(input string dn, input logic en, input logic [AW:0] addr,
                             input logic [11:0] rgb, input logic hs, input logic vs,
                             input logic de);
    check({dn, " rst rd_en"}, 32'(en), 32'd0);
    check({dn, " rst rd_addr"}, 32'(addr), 32'd0);
    check({dn, " rst rgb"}, 32'(rgb), 32'd0);
    check({dn, " rst hsync_o"}, 32'(hs), 32'd1);
    check({dn, " rst vsync_o"}, 32'(vs), 32'd1);
    check({dn, " rst de_o"}, 32'(de), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic apply(input int xi, input int yi);
    vec_t cur;
    x        = 10'(xi);
    y        = 10'(yi);
    video_on = (xi < 640) && (yi < 480);
    hsync    = !((xi >= 656) && (xi < 752));
    vsync    = !((yi >= 490) && (yi < 492));
    if (xi == 0 && yi == 0) exp_buf = buf_sel;
    cur = '{v: 1'b1, x: xi, y: yi, von: video_on, hs: hsync, vs: vsync, bsel: exp_buf};
    @(posedge pclk);
    #1;
    h2 = h1;
    h1 = h0;
    h0 = cur;
    check_pipe("a", 320, 12'h000, bus_a.rd_en, bus_a.rd_addr, {r_a, g_a, b_a}, hs_a, vs_a, de_a);
    check_pipe("b", 256, BORDER_B, bus_b.rd_en, bus_b.rd_addr, {r_b, g_b, b_b}, hs_b, vs_b, de_b);
  endtask

  task automatic apply_list(input int yi, input int xs[]);
    foreach (xs[i]) apply(xs[i], yi);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_hist();
    #1 rst = 1'b1;
    #1;
    check_reset("a", bus_a.rd_en, bus_a.rd_addr, {r_a, g_a, b_a}, hs_a, vs_a, de_a);
    check_reset("b", bus_b.rd_en, bus_b.rd_addr, {r_b, g_b, b_b}, hs_b, vs_b, de_b);
    @(negedge pclk);
    rst = 1'b0;

    // Frame 0, buffer 0. First pixel: address 0 one cycle after sampling, ABC three after input.
    apply(0, 0);
    apply(1, 0);
    check("first rd_addr", 32'(bus_a.rd_addr), 32'd0);
    apply(2, 0);
    check("first rgb", 32'({r_a, g_a, b_a}), 32'h0ABC);
    apply_list(0, '{3, 4, 5, 318, 319, 636, 637, 638, 639, 640, 641, 655, 656, 657,
                    750, 751, 752, 798, 799});
    apply_list(1, '{0, 1, 2, 3, 510, 511, 512, 513, 639, 640});
    apply(0, 2);
    apply(1, 2);
    check("row2 rd_addr", 32'(bus_a.rd_addr), 32'd320);
    for (int yy = 3; yy < 100; yy++) begin
      apply(0, yy);
      apply((yy * 13) % 800, yy);
    end
    buf_sel = 1'b1;
    for (int yy = 100; yy < 478; yy++) begin
      apply(0, yy);
      apply((yy * 7) % 800, yy);
    end
    apply_list(478, '{0, 639});
    apply_list(479, '{0, 510, 511, 512, 513, 638, 639});
    apply(640, 479);
    check("last rd_addr", 32'(bus_a.rd_addr), 32'h12BFF);
    apply_list(479, '{656, 751, 752});
    for (int yy = 480; yy < 525; yy++) begin
      apply(0, yy);
      apply(700, yy);
    end

    // Frame 1 picks up buffer 1.
    apply(0, 0);
    apply(1, 0);
    check("buf1 rd_addr", 32'(bus_a.rd_addr), 32'h20000);
    apply_list(0, '{2, 3});
    apply_list(1, '{0, 5, 6, 7});

    // Reset in the middle of a line.
    #2 rst = 1'b1;
    #1;
    check_reset("a mid", bus_a.rd_en, bus_a.rd_addr, {r_a, g_a, b_a}, hs_a, vs_a, de_a);
    check_reset("b mid", bus_b.rd_en, bus_b.rd_addr, {r_b, g_b, b_b}, hs_b, vs_b, de_b);
    #1 rst = 1'b0;
    clear_hist();
    exp_buf = 1'b0;
    apply_list(1, '{700, 701, 702});
    apply_list(0, '{0, 1, 2, 3, 600});
    apply_list(1, '{0, 1, 2, 3, 520});
    apply_list(2, '{0, 1, 2, 700, 701, 702});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
